ttt_game_ctrl: RTL and testbench

Upstream game-state engine for the 16x16 LED tic-tac-toe display. It accepts cell-select and place inputs from the board switches and keys, and holds the 9-cell board. It alternates turns, rejects illegal moves, and detects win or draw. Its currentGame output drives the glyph-overlay stage directly.

---
 rtl/ttt_pkg.sv | 11 +
 rtl/ttt_win_detect.sv | 25 ++
 rtl/ttt_game_ctrl.sv | 102 ++++++++++
 tb/tb_ttt_game_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell/state encodings and win-line table for the tic-tac-toe controller
package ttt_pkg;
    typedef enum logic [1:0] {EMPTY = 2'b00, PX = 2'b01, PO = 2'b10} cell_t;
    typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;
    localparam int NUM_CELLS = 9;
    localparam int WIN_LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };
endpackage

// File: rtl/ttt_win_detect.sv
// ttt_win_detect: combinational three-in-a-row and full-board detection
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [8:0][1:0] board,
    output logic            win,
    output logic [1:0]      win_player,
    output logic            full
);
    // scan all eight lines and every cell for emptiness
    always_comb begin
        win = 1'b0;
        win_player = EMPTY;
        full = 1'b1;
        for (int i = 0; i < 8; i++)
            if (board[WIN_LINES[i][0]] != EMPTY &&
                board[WIN_LINES[i][0]] == board[WIN_LINES[i][1]] &&
                board[WIN_LINES[i][0]] == board[WIN_LINES[i][2]]) begin
                win = 1'b1;
                win_player = board[WIN_LINES[i][0]];
            end
        for (int i = 0; i < NUM_CELLS; i++)
            if (board[i] == EMPTY) full = 1'b0;
    end
endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game-state engine; TTT_SCORE_EN enables the per-player win counters
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter int         SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         cell_sel,
    input  logic               place,
    input  logic               new_game,
    output logic [8:0][1:0]    currentGame,
    output logic [1:0]         turn,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               illegal_move,
    output logic [SCORE_W-1:0] x_wins,
    output logic [SCORE_W-1:0] o_wins
);
    state_t state;
    logic   place_q;
    logic   place_edge;
    logic   legal;
    logic   win;
    logic   full;
    logic [1:0] win_player;

    assign place_edge = place & ~place_q;
    assign legal = (cell_sel < 4'd9) && (currentGame[cell_sel] == EMPTY);

    ttt_win_detect u_win (
        .board(currentGame),
        .win(win),
        .win_player(win_player),
        .full(full)
    );

    // game FSM: new_game overrides everything, moves are written then checked one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PLAY;
            place_q <= 1'b0;
            currentGame <= '0;
            turn <= FIRST_PLAYER;
            winner <= EMPTY;
            game_over <= 1'b0;
            illegal_move <= 1'b0;
        end else begin
            place_q <= place;
            illegal_move <= 1'b0;
            if (new_game) begin
                state <= PLAY;
                currentGame <= '0;
                turn <= FIRST_PLAYER;
                winner <= EMPTY;
                game_over <= 1'b0;
            end else begin
                case (state)
                    PLAY:
                        if (place_edge) begin
                            if (legal) begin
                                currentGame[cell_sel] <= turn;
                                state <= CHECK;
                            end else begin
                                illegal_move <= 1'b1;
                            end
                        end
                    CHECK:
                        if (win) begin
                            state <= WIN;
                            winner <= win_player;
                            game_over <= 1'b1;
                        end else if (full) begin
                            state <= DRAW;
                            game_over <= 1'b1;
                        end else begin
                            turn <= {turn[0], turn[1]};
                            state <= PLAY;
                        end
                    default: ;
                endcase
            end
        end
    end

`ifdef TTT_SCORE_EN
    // saturating win counters bumped on the CHECK -> WIN transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_wins <= '0;
            o_wins <= '0;
        end else if (!new_game && state == CHECK && win) begin
            if (win_player == PX && !(&x_wins)) x_wins <= x_wins + 1'b1;
            if (win_player == PO && !(&o_wins)) o_wins <= o_wins + 1'b1;
        end
    end
`else
    assign x_wins = '0;
    assign o_wins = '0;
`endif
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: vector table, hand sequences and randomized play against a rule-level model
module tb_ttt_game_ctrl;
    localparam int SW = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       cell_sel = '0;
    logic             place = 1'b0;
    logic             new_game = 1'b0;
    logic [8:0][1:0]  currentGame;
    logic [1:0]       turn;
    logic             game_over;
    logic [1:0]       winner;
    logic             illegal_move;
    logic [SW-1:0]    x_wins;
    logic [SW-1:0]    o_wins;

    int nchk = 0;
    int nerr = 0;

    ttt_game_ctrl #(.FIRST_PLAYER(2'b01), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset), .cell_sel(cell_sel), .place(place),
        .new_game(new_game), .currentGame(currentGame), .turn(turn),
        .game_over(game_over), .winner(winner), .illegal_move(illegal_move),
        .x_wins(x_wins), .o_wins(o_wins)
    );

    always #5 clk = ~clk;

    // model: board of player numbers (0 empty, 1 X, 2 O)
    int mb [9];
    int mturn, mwin, mover, mill, mxw, mow, mpq;
    int mphase;

    typedef struct {
        int    pl;
        int    cs;
        int    ng;
        string bd;
        int    tn;
        int    ov;
        int    wn;
        int    il;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(int pl, int cs, int ng, string bd, int tn, int ov, int wn, int il);
        vec_t v;
        v.pl = pl; v.cs = cs; v.ng = ng; v.bd = bd;
        v.tn = tn; v.ov = ov; v.wn = wn; v.il = il;
        return v;
    endfunction

    function automatic string dut_board();
        string s = "";
        for (int i = 0; i < 9; i++)
            s = {s, currentGame[i] == 2'b00 ? "." : currentGame[i] == 2'b01 ? "X" :
                    currentGame[i] == 2'b10 ? "O" : "?"};
        return s;
    endfunction

    function automatic string model_board();
        string s = "";
        for (int i = 0; i < 9; i++) s = {s, mb[i] == 0 ? "." : mb[i] == 1 ? "X" : "O"};
        return s;
    endfunction

    function automatic int who_won();
        for (int r = 0; r < 3; r++) begin
            if (mb[3*r] != 0 && mb[3*r] == mb[3*r+1] && mb[3*r] == mb[3*r+2]) return mb[3*r];
            if (mb[r] != 0 && mb[r] == mb[r+3] && mb[r] == mb[r+6]) return mb[r];
        end
        if (mb[4] != 0 && ((mb[0] == mb[4] && mb[8] == mb[4]) || (mb[2] == mb[4] && mb[6] == mb[4])))
            return mb[4];
        return 0;
    endfunction

    function automatic int filled();
        int n = 0;
        for (int i = 0; i < 9; i++) if (mb[i] != 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mb[i] = 0;
        mturn = 1; mwin = 0; mover = 0; mill = 0; mxw = 0; mow = 0; mpq = 0; mphase = 0;
    endtask

    task automatic model_clock(input int pl, input int cs, input int ng);
        int pe, w;
        pe = (pl != 0 && mpq == 0);
        mpq = pl;
        mill = 0;
        if (ng != 0) begin
            for (int i = 0; i < 9; i++) mb[i] = 0;
            mturn = 1; mwin = 0; mover = 0; mphase = 0;
        end else if (mphase == 0) begin
            if (pe) begin
                if (cs < 9 && mb[cs] == 0) begin
                    mb[cs] = mturn;
                    mphase = 1;
                end else mill = 1;
            end
        end else if (mphase == 1) begin
            w = who_won();
            if (w != 0) begin
                mwin = w; mover = 1; mphase = 2;
`ifdef TTT_SCORE_EN
                if (w == 1 && mxw < (1 << SW) - 1) mxw++;
                if (w == 2 && mow < (1 << SW) - 1) mow++;
`endif
            end else if (filled() == 9) begin
                mover = 1; mphase = 2;
            end else begin
                mturn = 3 - mturn; mphase = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic chk_model();
        chk_s("board", dut_board(), model_board());
        chk("turn", int'(turn), mturn);
        chk("game_over", int'(game_over), mover);
        chk("winner", int'(winner), mwin);
        chk("illegal_move", int'(illegal_move), mill);
        chk("x_wins", int'(x_wins), mxw);
        chk("o_wins", int'(o_wins), mow);
    endtask

    task automatic step(input int pl, input int cs, input int ng);
        place = pl[0];
        cell_sel = cs[3:0];
        new_game = ng[0];
        @(posedge clk);
        model_clock(pl, cs, ng);
        @(negedge clk);
        chk_model();
    endtask

    task automatic move(input int cs);
        step(1, cs, 0);
        step(0, cs, 0);
    endtask

    task automatic chk_end(input string tag, input string bd, input int tn, input int ov, input int wn);
        chk_s({tag, ".board"}, dut_board(), bd);
        chk({tag, ".turn"}, int'(turn), tn);
        chk({tag, ".over"}, int'(game_over), ov);
        chk({tag, ".winner"}, int'(winner), wn);
    endtask

    initial begin
        model_reset();
        tbl.push_back(mk(1, 4, 0, "....X....", 1, 0, 0, 0));
        tbl.push_back(mk(0, 4, 0, "....X....", 2, 0, 0, 0));
        tbl.push_back(mk(1, 4, 0, "....X....", 2, 0, 0, 1));
        tbl.push_back(mk(0, 9, 0, "....X....", 2, 0, 0, 0));
        tbl.push_back(mk(1, 9, 0, "....X....", 2, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, "....X....", 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, "O...X....", 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, "O...X....", 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, "O...X....", 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, ".........", 1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, ".........", 1, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, ".........", 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, "X........", 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, "X........", 2, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, "X..O.....", 2, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, "X..O.....", 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, "XX.O.....", 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, "XX.O.....", 2, 0, 0, 0));
        tbl.push_back(mk(1, 4, 0, "XX.OO....", 2, 0, 0, 0));
        tbl.push_back(mk(0, 4, 0, "XX.OO....", 1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, "XXXOO....", 1, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, "XXXOO....", 1, 1, 1, 0));
        tbl.push_back(mk(1, 5, 0, "XXXOO....", 1, 1, 1, 0));
        tbl.push_back(mk(0, 5, 0, "XXXOO....", 1, 1, 1, 0));
        tbl.push_back(mk(1, 9, 0, "XXXOO....", 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, ".........", 1, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk_end("reset", ".........", 1, 0, 0);
        chk("reset.illegal", int'(illegal_move), 0);
        chk("reset.x_wins", int'(x_wins), 0);
        chk("reset.o_wins", int'(o_wins), 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[k]) begin
            step(tbl[k].pl, tbl[k].cs, tbl[k].ng);
            chk_s($sformatf("vec%0d.board", k), dut_board(), tbl[k].bd);
            chk($sformatf("vec%0d.turn", k), int'(turn), tbl[k].tn);
            chk($sformatf("vec%0d.over", k), int'(game_over), tbl[k].ov);
            chk($sformatf("vec%0d.winner", k), int'(winner), tbl[k].wn);
            chk($sformatf("vec%0d.illegal", k), int'(illegal_move), tbl[k].il);
        end

        foreach (mb[i]) mb[i] = mb[i];
        move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6); move(8);
        chk_end("draw", "XOXXOOOXX", 1, 1, 0);
        step(1, 0, 0);
        chk("draw.frozen_illegal", int'(illegal_move), 0);
        step(0, 0, 1);
        move(0); move(1); move(2); move(3); move(4); move(5); move(7); move(6); move(8);
        chk_end("win9", "XOXOXOOXX", 1, 1, 1);
        step(0, 0, 1);

        step(1, 4, 0);
        #2 reset = 1'b1;
        #1;
        chk_end("async_reset", ".........", 1, 0, 0);
        chk("async_reset.x_wins", int'(x_wins), 0);
        model_reset();
        place = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_model();

        for (int n = 0; n < 4000; n++)
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                 ($urandom_range(0, 39) == 0) ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
